eth_phy_reset_seq: RTL and testbench

//  Power-up and lock-loss sequencer for the RGMII PHY and TSE/Nios core.

---
 rtl/eth_phy_reset_seq_if.sv | 37 +++
 rtl/eth_phy_reset_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_eth_phy_reset_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_phy_reset_seq_if.sv
// Signal bundle between the reset sequencer and the rest of the lab3 top
// level: PLL lock and TSE speed status in, PHY/core resets and speed mux
// select out.
interface eth_phy_reset_seq_if;
    logic       pll_locked;
    logic       eth_mode;
    logic       ena_10;
    logic       enet_rst_n;
    logic       core_reset_n;
    logic [1:0] speed_sel;
    logic       speed_change;
    logic [2:0] seq_state;

    // System side: drives lock/speed status, observes resets and speed select.
    modport master (
        output pll_locked,
        output eth_mode,
        output ena_10,
        input  enet_rst_n,
        input  core_reset_n,
        input  speed_sel,
        input  speed_change,
        input  seq_state
    );

    // Sequencer side.
    modport slave (
        input  pll_locked,
        input  eth_mode,
        input  ena_10,
        output enet_rst_n,
        output core_reset_n,
        output speed_sel,
        output speed_change,
        output seq_state
    );
endinterface

// File: rtl/eth_phy_reset_seq.sv
// Power-up / lock-loss sequencer for the RGMII PHY and the TSE/Nios core.
// Waits for a stable PLL lock, holds the PHY in hardware reset, gives the
// PHY time to come up, then releases the core. While running it debounces
// the TSE speed status into a clock-mux select and pulses on every change.
module eth_phy_reset_seq #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int PHY_RST_CYCLES      = 500000,
    parameter int PHY_WAIT_CYCLES     = 100000,
    parameter int SPEED_STABLE_CYCLES = 256,
    parameter int CNT_W               = 20
) (
    input  logic                 clk_50,
    input  logic                 reset,
    eth_phy_reset_seq_if.slave   bus
);

    // ------------------------------------------------------------------
    // State encoding (fixed values, also exported on seq_state)
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_WAIT_LOCK   = 3'd0;
    localparam logic [2:0] ST_LOCK_STABLE = 3'd1;
    localparam logic [2:0] ST_PHY_RST     = 3'd2;
    localparam logic [2:0] ST_PHY_WAIT    = 3'd3;
    localparam logic [2:0] ST_RUN         = 3'd4;

    // Terminal counts: a timed state lasting N cycles leaves when the
    // counter, started at 0 on entry, reaches N-1.
    localparam logic [CNT_W-1:0] LOCK_TERM  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_TERM   = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_TERM  = CNT_W'(PHY_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPEED_TERM = CNT_W'(SPEED_STABLE_CYCLES - 1);

    localparam longint CNT_SPAN = longint'(1) << CNT_W;

    // Refuse to elaborate if the shared counter cannot reach a terminal count.
    if ((CNT_SPAN <= longint'(LOCK_STABLE_CYCLES))  ||
        (CNT_SPAN <= longint'(PHY_RST_CYCLES))      ||
        (CNT_SPAN <= longint'(PHY_WAIT_CYCLES))     ||
        (CNT_SPAN <= longint'(SPEED_STABLE_CYCLES)) ||
        (LOCK_STABLE_CYCLES < 1) || (PHY_RST_CYCLES < 1) ||
        (PHY_WAIT_CYCLES < 1) || (SPEED_STABLE_CYCLES < 1)) begin : g_bad_params
        $error("eth_phy_reset_seq: CNT_W too small or a cycle parameter below 1");
    end

    // ------------------------------------------------------------------
    // Input synchronisers: bit 0 = pll_locked, 1 = eth_mode, 2 = ena_10
    // ------------------------------------------------------------------
    logic [2:0] async_in;
    logic [2:0] sync_bits;

    assign async_in = {bus.ena_10, bus.eth_mode, bus.pll_locked};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-flop synchroniser for one asynchronous status input.
            always_ff @(posedge clk_50 or posedge reset) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    logic locked_s;
    logic eth_mode_s;
    logic ena_10_s;

    assign locked_s   = sync_bits[0];
    assign eth_mode_s = sync_bits[1];
    assign ena_10_s   = sync_bits[2];

    // ------------------------------------------------------------------
    // Sequencer FSM and shared timing counter
    // ------------------------------------------------------------------
    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] term_cnt;
    logic             cnt_at_term;

    // Select the terminal count belonging to the current timed state.
    always_comb begin
        term_cnt = '0;
        case (state_reg)
            ST_LOCK_STABLE: term_cnt = LOCK_TERM;
            ST_PHY_RST:     term_cnt = RST_TERM;
            ST_PHY_WAIT:    term_cnt = WAIT_TERM;
            default:        term_cnt = '0;
        endcase
    end

    assign cnt_at_term = (cnt_reg == term_cnt);

    // Next-state logic; lock loss has priority over any terminal count.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_WAIT_LOCK: begin
                cnt_next = '0;
                if (locked_s) begin
                    state_next = ST_LOCK_STABLE;
                end
            end
            ST_LOCK_STABLE: begin
                if (cnt_at_term) begin
                    state_next = ST_PHY_RST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PHY_RST: begin
                if (cnt_at_term) begin
                    state_next = ST_PHY_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PHY_WAIT: begin
                if (cnt_at_term) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
            end
            default: begin
                state_next = ST_WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase

        if (!locked_s && (state_reg != ST_WAIT_LOCK)) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_reg <= ST_WAIT_LOCK;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Reset outputs: registered from the next state so they never glitch
    // and change on the same edge as the state they belong to.
    // ------------------------------------------------------------------
    logic enet_rst_n_reg;
    logic core_reset_n_reg;

    // PHY is out of reset in PHY_WAIT and RUN; the core only in RUN.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            enet_rst_n_reg   <= 1'b0;
            core_reset_n_reg <= 1'b0;
        end else begin
            enet_rst_n_reg   <= (state_next == ST_PHY_WAIT) || (state_next == ST_RUN);
            core_reset_n_reg <= (state_next == ST_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Speed debounce
    // ------------------------------------------------------------------
    logic [1:0]       speed_code;
    logic [1:0]       cand_reg;
    logic [1:0]       cand_next;
    logic [CNT_W-1:0] stab_reg;
    logic [CNT_W-1:0] stab_next;
    logic [1:0]       sel_reg;
    logic [1:0]       sel_next;
    logic             pulse_reg;
    logic             pulse_next;

    // GbE wins over the 10 Mb flag; neither set means 100 Mb.
    always_comb begin
        speed_code = 2'b00;
        if (eth_mode_s) begin
            speed_code = 2'b10;
        end else if (ena_10_s) begin
            speed_code = 2'b01;
        end
    end

    // Track the candidate code and publish it once it has held long enough;
    // everything returns to 00 whenever the sequencer is not running.
    always_comb begin
        cand_next  = cand_reg;
        stab_next  = stab_reg;
        sel_next   = sel_reg;
        pulse_next = 1'b0;
        if (state_next != ST_RUN) begin
            cand_next = 2'b00;
            stab_next = '0;
            sel_next  = 2'b00;
        end else if (state_reg == ST_RUN) begin
            if (speed_code != cand_reg) begin
                cand_next = speed_code;
                stab_next = '0;
            end else if (stab_reg != SPEED_TERM) begin
                stab_next = stab_reg + 1'b1;
            end else if (cand_reg != sel_reg) begin
                sel_next   = cand_reg;
                pulse_next = 1'b1;
            end
        end
    end

    // Debounce registers.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            cand_reg  <= 2'b00;
            stab_reg  <= '0;
            sel_reg   <= 2'b00;
            pulse_reg <= 1'b0;
        end else begin
            cand_reg  <= cand_next;
            stab_reg  <= stab_next;
            sel_reg   <= sel_next;
            pulse_reg <= pulse_next;
        end
    end

    assign bus.enet_rst_n   = enet_rst_n_reg;
    assign bus.core_reset_n = core_reset_n_reg;
    assign bus.speed_sel    = sel_reg;
    assign bus.speed_change = pulse_reg;
    assign bus.seq_state    = state_reg;

endmodule

// File: tb/tb_eth_phy_reset_seq.sv
// Bench for eth_phy_reset_seq with short timing parameters. A behavioural
// model derives the expected state from elapsed time since the lock was
// seen and the expected speed select from the run length of the speed code.
module tb_eth_phy_reset_seq;

    localparam int LS = 4;
    localparam int PR = 10;
    localparam int PW = 6;
    localparam int SS = 3;

    logic clk_50 = 1'b0;
    logic reset  = 1'b1;

    eth_phy_reset_seq_if bus ();

    eth_phy_reset_seq #(
        .LOCK_STABLE_CYCLES  (LS),
        .PHY_RST_CYCLES      (PR),
        .PHY_WAIT_CYCLES     (PW),
        .SPEED_STABLE_CYCLES (SS),
        .CNT_W               (20)
    ) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_50 = ~clk_50;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state
    bit       lk_q [2];
    bit [1:0] cq   [2];
    int       m_state;
    int       edge_n;
    int       entry_edge;
    bit [1:0] m_sel;
    bit       m_pulse;
    bit [1:0] m_prev;
    int       m_eq;
    int       pulse_obs;

    function automatic bit [1:0] speed_code(input bit em, input bit e10);
        if (em)  return 2'b10;
        if (e10) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        lk_q[0] = 0; lk_q[1] = 0;
        cq[0] = 2'b00; cq[1] = 2'b00;
        m_state = 0; entry_edge = 0;
        m_sel = 2'b00; m_pulse = 0; m_prev = 2'b00; m_eq = 0;
    endtask

    // One clock edge of the model; inputs take two edges to become visible.
    task automatic model_edge(input bit rst, input bit lk, input bit [1:0] code);
        int ns;
        int e;
        bit [1:0] c;
        edge_n++;
        if (rst) begin
            model_clear();
            return;
        end
        m_pulse = 0;
        if (!lk_q[1]) begin
            ns = 0;
        end else if (m_state == 0) begin
            ns = 1;
            entry_edge = edge_n;
        end else begin
            e = edge_n - entry_edge;
            if (e < LS)                ns = 1;
            else if (e < LS + PR)      ns = 2;
            else if (e < LS + PR + PW) ns = 3;
            else                       ns = 4;
        end
        if (ns != 4) begin
            m_sel = 2'b00; m_prev = 2'b00; m_eq = 0;
        end else if (m_state == 4) begin
            c = cq[1];
            if (c == m_prev) m_eq++;
            else             m_eq = 0;
            m_prev = c;
            if (m_eq >= SS && m_sel != c) begin
                m_sel = c;
                m_pulse = 1;
            end
        end
        m_state = ns;
        lk_q[1] = lk_q[0]; lk_q[0] = lk;
        cq[1] = cq[0];     cq[0] = code;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("enet_rst_n",   8'(bus.enet_rst_n),   8'((m_state == 3) || (m_state == 4)));
        check("core_reset_n", 8'(bus.core_reset_n), 8'(m_state == 4));
        check("seq_state",    8'(bus.seq_state),    8'(m_state));
        check("speed_sel",    8'(bus.speed_sel),    8'(m_sel));
        check("speed_change", 8'(bus.speed_change), 8'(m_pulse));
    endtask

    // Advance one clock: inputs are those present at the rising edge,
    // outputs are sampled on the following falling edge.
    task automatic step();
        bit r;
        bit lk;
        bit [1:0] c;
        r  = reset;
        lk = bus.pll_locked;
        c  = speed_code(bus.eth_mode, bus.ena_10);
        @(posedge clk_50);
        model_edge(r, lk, c);
        @(negedge clk_50);
        check_outputs();
        if (bus.speed_change === 1'b1) pulse_obs++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until seq_state reaches target; the number of edges taken is compared.
    task automatic run_until(input string tag, input logic [2:0] target, input int exp_n);
        int n;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (bus.seq_state === target) begin
                n = i;
                break;
            end
        end
        check(tag, 8'(n), 8'(exp_n));
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        bus.eth_mode   = 1'b0;
        bus.ena_10     = 1'b0;
        edge_n         = 0;
        pulse_obs      = 0;
        model_clear();

        // Reset state
        steps(3);

        // Case 1: lock sampled at edge 1 -> PHY_WAIT at 17, RUN at 23
        reset = 1'b0;
        bus.pll_locked = 1'b1;
        run_until("lat_phy_wait", 3'd3, LS + PR + 3);
        run_until("lat_run", 3'd4, PW);

        // Lock loss from RUN takes three edges to reach WAIT_LOCK
        bus.pll_locked = 1'b0;
        run_until("lat_lock_loss", 3'd0, 3);

        // Case 2: drop lock inside PHY_RST, then replay full timing
        bus.pll_locked = 1'b1;
        steps(12);
        check("in_phy_rst", 8'(bus.seq_state), 8'd2);
        bus.pll_locked = 1'b0;
        run_until("lat_abort", 3'd0, 3);
        check("abort_enet", 8'(bus.enet_rst_n), 8'd0);
        bus.pll_locked = 1'b1;
        run_until("replay_run", 3'd4, LS + PR + PW + 3);

        // Case 3: GbE selected with one pulse; adding ena_10 changes nothing
        pulse_obs = 0;
        bus.eth_mode = 1'b1;
        steps(8);
        check("gbe_sel", 8'(bus.speed_sel), 8'd2);
        check("gbe_pulses", 8'(pulse_obs), 8'd1);
        pulse_obs = 0;
        bus.ena_10 = 1'b1;
        steps(8);
        check("gbe_e10_sel", 8'(bus.speed_sel), 8'd2);
        check("gbe_e10_pulses", 8'(pulse_obs), 8'd0);

        // Back to 100 Mb, then case 4: ena_10 toggling never settles
        pulse_obs = 0;
        bus.eth_mode = 1'b0;
        bus.ena_10   = 1'b0;
        steps(8);
        check("fe_sel", 8'(bus.speed_sel), 8'd0);
        check("fe_pulses", 8'(pulse_obs), 8'd1);
        pulse_obs = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) bus.ena_10 = ~bus.ena_10;
            step();
        end
        check("toggle_sel", 8'(bus.speed_sel), 8'd0);
        check("toggle_pulses", 8'(pulse_obs), 8'd0);

        // Case 5: 10 Mb selected, then lock loss clears everything quietly
        bus.ena_10 = 1'b1;
        steps(8);
        check("ten_sel", 8'(bus.speed_sel), 8'd1);
        pulse_obs = 0;
        bus.pll_locked = 1'b0;
        steps(3);
        check("loss_core", 8'(bus.core_reset_n), 8'd0);
        check("loss_enet", 8'(bus.enet_rst_n), 8'd0);
        check("loss_sel", 8'(bus.speed_sel), 8'd0);
        check("loss_pulses", 8'(pulse_obs), 8'd0);

        // Case 6: asynchronous reset while in RUN
        bus.pll_locked = 1'b1;
        bus.eth_mode   = 1'($urandom_range(0, 1));
        run_until("pre_reset_run", 3'd4, LS + PR + PW + 3);
        steps(6);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check("async_enet", 8'(bus.enet_rst_n), 8'd0);
        check("async_core", 8'(bus.core_reset_n), 8'd0);
        check("async_sel", 8'(bus.speed_sel), 8'd0);
        check("async_state", 8'(bus.seq_state), 8'd0);
        check("async_change", 8'(bus.speed_change), 8'd0);
        step();
        reset = 1'b0;
        run_until("post_reset_run", 3'd4, LS + PR + PW + 3);

        // Randomised status traffic with occasional lock drops
        for (int t = 0; t < 300; t++) begin
            bus.eth_mode = ($urandom_range(0, 3) == 0);
            bus.ena_10   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) begin
                bus.pll_locked = 1'b0;
                steps(int'($urandom_range(1, 4)));
                bus.pll_locked = 1'b1;
            end
            steps(int'($urandom_range(1, 6)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
